// File: rtl/defines.sv
// defines: shared register-file widths and write-back constants
package defines;
   localparam int RegNum = 32;
   localparam int RegNumLog2 = $clog2(RegNum);
   typedef logic [31:0] RegBus;
   typedef logic [RegNumLog2-1:0] RegAddrBus;
   localparam RegBus ZeroWord = '0;
   localparam logic WriteEnable = 1'b1;
   localparam int WbQDepth = 2;
endpackage

// File: rtl/wb_defer_queue.sv
// wb_defer_queue: deferred-write FIFO with kill-by-address, pending lookup and occupancy
module wb_defer_queue
   import defines::*;
#(
   parameter int DATA_W = $bits(RegBus),
   parameter int ADDR_W = RegNumLog2,
   parameter int QDEPTH = WbQDepth
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [ADDR_W-1:0]          push_addr,
   input  logic [DATA_W-1:0]          push_data,
   input  logic                       kill,
   input  logic [ADDR_W-1:0]          kill_addr,
   input  logic                       pop,
   input  logic [ADDR_W-1:0]          raddr1,
   input  logic [ADDR_W-1:0]          raddr2,
   output logic                       ready,
   output logic                       head_occ,
   output logic                       head_vld,
   output logic [ADDR_W-1:0]          head_addr,
   output logic [DATA_W-1:0]          head_data,
   output logic                       pend1,
   output logic                       pend2,
   output logic [$clog2(QDEPTH):0]    cnt
);
   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;
   logic [QDEPTH-1:0] vld;
   logic [ADDR_W-1:0] addr [QDEPTH];
   logic [DATA_W-1:0] data [QDEPTH];
   logic [PW-1:0]     hp, tp;
   logic              rdy, enq, keep;
   assign enq       = push && push_addr != '0;
   assign keep      = !(kill && kill_addr == push_addr);
   assign ready     = rdy && cnt != CW'(QDEPTH);
   assign head_occ  = cnt != '0;
   assign head_vld  = vld[hp];
   assign head_addr = addr[hp];
   assign head_data = data[hp];
   // control state: entry valid bits, pointers, occupancy, post-reset ready
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         rdy <= 1'b0;
         vld <= '0;
         hp  <= '0;
         tp  <= '0;
         cnt <= '0;
      end else begin
         rdy <= 1'b1;
         for (int i = 0; i < QDEPTH; i++)
            if (kill && addr[i] == kill_addr) vld[i] <= 1'b0;
         if (pop) begin
            vld[hp] <= 1'b0;
            hp      <= hp + PW'(1);
         end
         if (enq) begin
            vld[tp] <= keep;
            tp      <= tp + PW'(1);
         end
         cnt <= cnt + CW'(enq) - CW'(pop);
      end
   // payload storage, written only on enqueue
   always_ff @(posedge clk)
      if (enq) begin
         addr[tp] <= push_addr;
         data[tp] <= push_data;
      end
   // pending lookup over live entries for both ID read ports
   always_comb begin
      pend1 = 1'b0;
      pend2 = 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
         pend1 = pend1 | (vld[i] && addr[i] == raddr1);
         pend2 = pend2 | (vld[i] && addr[i] == raddr2);
      end
      pend1 = pend1 && raddr1 != '0;
      pend2 = pend2 && raddr2 != '0;
   end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register plus deferred side-unit writes sharing one write port
module wb_stage
   import defines::*;
#(
   parameter int DATA_W = $bits(RegBus),
   parameter int ADDR_W = RegNumLog2,
   parameter int QDEPTH = WbQDepth
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    mem_wreg,
   input  logic [ADDR_W-1:0]       mem_wd,
   input  logic [DATA_W-1:0]       mem_wdata,
   input  logic                    wb_stall,
   input  logic                    wb_flush,
   input  logic                    lu_valid,
   output logic                    lu_ready,
   input  logic [ADDR_W-1:0]       lu_waddr,
   input  logic [DATA_W-1:0]       lu_wdata,
   output logic                    we,
   output logic [ADDR_W-1:0]       waddr,
   output logic [DATA_W-1:0]       wdata,
   input  logic [ADDR_W-1:0]       raddr1,
   input  logic [ADDR_W-1:0]       raddr2,
   output logic                    pend1,
   output logic                    pend2,
   output logic [$clog2(QDEPTH):0] q_cnt
);
   logic              p_wreg;
   logic [ADDR_W-1:0] p_wd;
   logic [DATA_W-1:0] p_wdata;
   logic              capture, kill, pop, hocc, hvld, hwr;
   logic [ADDR_W-1:0] haddr;
   logic [DATA_W-1:0] hdata;
   assign capture = mem_wreg && mem_wd != '0;
   assign kill    = capture && !wb_stall && !wb_flush;
   assign hwr     = hocc && hvld;
   assign pop     = hocc && (!hvld || !p_wreg);
   // MEM/WB register: flush beats stall, r0 writes are dropped at capture
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         p_wreg  <= 1'b0;
         p_wd    <= '0;
         p_wdata <= '0;
      end else if (wb_flush) p_wreg <= 1'b0;
      else if (!wb_stall) begin
         p_wreg  <= capture;
         p_wd    <= mem_wd;
         p_wdata <= mem_wdata;
      end
   // write-port arbitration: pipeline first, then a live queue head
   always_comb begin
      we    = p_wreg ? WriteEnable : hwr;
      waddr = p_wreg ? p_wd : hwr ? haddr : '0;
      wdata = p_wreg ? p_wdata : hwr ? hdata : DATA_W'(ZeroWord);
   end
   wb_defer_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .QDEPTH(QDEPTH)) u_q (
      .clk(clk), .rst(rst),
      .push(lu_valid && lu_ready), .push_addr(lu_waddr), .push_data(lu_wdata),
      .kill(kill), .kill_addr(mem_wd), .pop(pop),
      .raddr1(raddr1), .raddr2(raddr2),
      .ready(lu_ready), .head_occ(hocc), .head_vld(hvld),
      .head_addr(haddr), .head_data(hdata),
      .pend1(pend1), .pend2(pend2), .cnt(q_cnt)
   );
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage write ordering, queue flow control and kills
module tb_wb_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        mem_wreg, wb_stall, wb_flush, lu_valid, lu_ready, we, pend1, pend2;
   logic [4:0]  mem_wd, lu_waddr, waddr, raddr1, raddr2;
   logic [31:0] mem_wdata, lu_wdata, wdata;
   logic [1:0]  q_cnt;
   logic [36:0] exp_q [$];
   int          n_vec = 0;
   int          n_err = 0;

   wb_stage dut (
      .clk(clk), .rst(rst), .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
      .wb_stall(wb_stall), .wb_flush(wb_flush), .lu_valid(lu_valid), .lu_ready(lu_ready),
      .lu_waddr(lu_waddr), .lu_wdata(lu_wdata), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .raddr2(raddr2), .pend1(pend1), .pend2(pend2), .q_cnt(q_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
      exp_q.push_back({a, d});
   endtask

   // every register-file write must match the next expected write in order
   always @(negedge clk)
      if (rst && we) begin
         if (exp_q.size() == 0) check("wr_extra", {63'd0, we}, 64'd0);
         else check("wr", {27'd0, waddr, wdata}, {27'd0, exp_q.pop_front()});
      end

   initial begin
      rst = 1'b0; wb_stall = 0; wb_flush = 0;
      mem_wreg = 1; mem_wd = 3; mem_wdata = 32'h1;
      lu_valid = 1; lu_waddr = 9; lu_wdata = 32'h9; raddr1 = 9; raddr2 = 3;
      repeat (3) step();
      check("rst_we", {63'd0, we}, 0);
      check("rst_waddr", {59'd0, waddr}, 0);
      check("rst_wdata", {32'd0, wdata}, 0);
      check("rst_pend1", {63'd0, pend1}, 0);
      check("rst_pend2", {63'd0, pend2}, 0);
      check("rst_qcnt", {62'd0, q_cnt}, 0);
      check("rst_ready", {63'd0, lu_ready}, 0);
      mem_wreg = 0; lu_valid = 0; rst = 1'b1;
      step();
      check("rel_ready", {63'd0, lu_ready}, 1);
      check("rel_we", {63'd0, we}, 0);
      // pipeline-only write, then an r0 capture
      expect_wr(3, 32'h1234);
      mem_wreg = 1; mem_wd = 3; mem_wdata = 32'h1234;
      step();
      check("p_we", {63'd0, we}, 1);
      mem_wd = 0; mem_wdata = 32'hdead;
      step();
      mem_wreg = 0;
      check("r0_we", {63'd0, we}, 0);
      step();
      // side write waits behind three pipeline writes
      expect_wr(1, 32'h11); expect_wr(1, 32'h12); expect_wr(1, 32'h13); expect_wr(5, 32'haaaa);
      raddr1 = 5;
      mem_wreg = 1; mem_wd = 1; mem_wdata = 32'h11;
      lu_valid = 1; lu_waddr = 5; lu_wdata = 32'haaaa;
      step();
      lu_valid = 0;
      check("busy_pend_a", {63'd0, pend1}, 1);
      check("busy_qcnt", {62'd0, q_cnt}, 1);
      mem_wdata = 32'h12;
      step();
      check("busy_pend_b", {63'd0, pend1}, 1);
      mem_wdata = 32'h13;
      step();
      check("busy_pend_c", {63'd0, pend1}, 1);
      mem_wreg = 0;
      step();
      check("side_wr_pend", {63'd0, pend1}, 1);
      check("side_wr_addr", {59'd0, waddr}, 5);
      step();
      check("side_done_pend", {63'd0, pend1}, 0);
      check("side_done_qcnt", {62'd0, q_cnt}, 0);
      // full queue back-pressure
      expect_wr(1, 32'h21); expect_wr(1, 32'h22); expect_wr(6, 32'h66);
      expect_wr(8, 32'h88); expect_wr(10, 32'hbb);
      mem_wreg = 1; mem_wd = 1; mem_wdata = 32'h21;
      lu_valid = 1; lu_waddr = 6; lu_wdata = 32'h66;
      step();
      check("fill1_qcnt", {62'd0, q_cnt}, 1);
      check("fill1_ready", {63'd0, lu_ready}, 1);
      lu_waddr = 8; lu_wdata = 32'h88; mem_wdata = 32'h22;
      step();
      check("full_qcnt", {62'd0, q_cnt}, 2);
      check("full_ready", {63'd0, lu_ready}, 0);
      mem_wreg = 0; lu_waddr = 10; lu_wdata = 32'hbb;
      step();
      check("full_hold_qcnt", {62'd0, q_cnt}, 2);
      check("full_hold_ready", {63'd0, lu_ready}, 0);
      step();
      check("pop1_qcnt", {62'd0, q_cnt}, 1);
      check("pop1_ready", {63'd0, lu_ready}, 1);
      step();
      lu_valid = 0;
      check("pushpop_qcnt", {62'd0, q_cnt}, 1);
      step();
      check("drain_qcnt", {62'd0, q_cnt}, 0);
      step();
      // kill of a queued entry by a younger pipeline capture
      expect_wr(1, 32'h31); expect_wr(7, 32'h2);
      raddr2 = 7;
      mem_wreg = 1; mem_wd = 1; mem_wdata = 32'h31;
      lu_valid = 1; lu_waddr = 7; lu_wdata = 32'h1;
      step();
      lu_valid = 0;
      check("kill_pre_pend", {63'd0, pend2}, 1);
      mem_wd = 7; mem_wdata = 32'h2;
      step();
      mem_wreg = 0;
      check("kill_pend", {63'd0, pend2}, 0);
      check("kill_qcnt", {62'd0, q_cnt}, 1);
      step();
      check("kill_silent_we", {63'd0, we}, 0);
      check("kill_silent_qcnt", {62'd0, q_cnt}, 0);
      // same-cycle side push and pipeline capture to the same register
      expect_wr(7, 32'h22);
      mem_wreg = 1; mem_wd = 7; mem_wdata = 32'h22;
      lu_valid = 1; lu_waddr = 7; lu_wdata = 32'h99;
      step();
      mem_wreg = 0; lu_valid = 0;
      check("same_qcnt", {62'd0, q_cnt}, 1);
      check("same_pend", {63'd0, pend2}, 0);
      step();
      check("same_qcnt_after", {62'd0, q_cnt}, 0);
      check("same_we_after", {63'd0, we}, 0);
      // stall repeats the write, flush releases the waiting queue entry
      expect_wr(4, 32'h44); expect_wr(4, 32'h44); expect_wr(4, 32'h44); expect_wr(12, 32'hcc);
      mem_wreg = 1; mem_wd = 4; mem_wdata = 32'h44;
      step();
      wb_stall = 1; mem_wd = 9; mem_wdata = 32'h99;
      check("stall1_addr", {59'd0, waddr}, 4);
      lu_valid = 1; lu_waddr = 12; lu_wdata = 32'hcc;
      step();
      lu_valid = 0;
      check("stall2_addr", {59'd0, waddr}, 4);
      step();
      check("stall3_addr", {59'd0, waddr}, 4);
      wb_flush = 1;
      step();
      check("flushq_we", {63'd0, we}, 1);
      check("flushq_addr", {59'd0, waddr}, 12);
      wb_flush = 0; wb_stall = 0; mem_wreg = 0;
      step();
      check("flushq_idle", {63'd0, we}, 0);
      check("flushq_qcnt", {62'd0, q_cnt}, 0);
      expect_wr(4, 32'h45);
      mem_wreg = 1; mem_wd = 4; mem_wdata = 32'h45;
      step();
      check("fs_pre_addr", {59'd0, waddr}, 4);
      wb_stall = 1; wb_flush = 1;
      step();
      check("flush_stall_we", {63'd0, we}, 0);
      wb_stall = 0; wb_flush = 0; mem_wreg = 0;
      step();
      // reset mid-operation drops the queued write
      expect_wr(1, 32'h51);
      raddr1 = 13;
      mem_wreg = 1; mem_wd = 1; mem_wdata = 32'h51;
      lu_valid = 1; lu_waddr = 13; lu_wdata = 32'hdd;
      step();
      mem_wreg = 0; lu_valid = 0;
      check("mid_pend", {63'd0, pend1}, 1);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_qcnt", {62'd0, q_cnt}, 0);
      check("mid_rst_we", {63'd0, we}, 0);
      check("mid_rst_pend", {63'd0, pend1}, 0);
      check("mid_rst_ready", {63'd0, lu_ready}, 0);
      step();
      rst = 1'b1;
      step();
      check("mid_rel_ready", {63'd0, lu_ready}, 1);
      check("mid_rel_qcnt", {62'd0, q_cnt}, 0);
      step();
      check("mid_rel_we", {63'd0, we}, 0);
      check("exp_drain", 64'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
